// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button front-end: cycle-count helpers and the
// auto-repeat state encoding.
package button_conditioner_pkg;

    // Auto-repeat FSM states (used only when BUTTON_CONDITIONER_AUTO_REPEAT_EN is defined)
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Directional button indices within the 4-bit direction vectors
    localparam int unsigned DIR_U = 0;
    localparam int unsigned DIR_D = 1;
    localparam int unsigned DIR_L = 2;
    localparam int unsigned DIR_R = 3;

    // Milliseconds to clock cycles, never less than one cycle.
    // The product is formed in 64 bits so 100 MHz * 500 ms does not overflow.
    function automatic int unsigned cycles_from_ms(input int unsigned freq, input int unsigned ms);
        longint unsigned prod;
        prod = (longint'(freq) * longint'(ms)) / 64'd1000;
        if (prod < 64'd1)
            return 1;
        return int'(prod);
    endfunction

    // Repeat rate in Hz to a period in cycles, never less than one cycle
    function automatic int unsigned period_from_rate(input int unsigned freq, input int unsigned rate);
        if (rate == 0 || freq < rate)
            return 1;
        return freq / rate;
    endfunction

    // Counter width able to hold 0 .. n-1
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 1)
            return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/button_conditioner_debouncer.sv
// One button lane: two-flop synchroniser, stable-time counter, debounced
// level and a registered rising-edge pulse (one cycle behind the level).
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          level_q;

    // Two-stage synchroniser for the asynchronous raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // Registered rising edge of the debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Button front-end: debounces five raw buttons, toggles the set-mode level on
// each centre press and turns up/down/left/right into one-cycle pulses.
// Opposing buttons on one axis cancel each other; when one of the pair is
// released while the other is still held, the survivor pulses then.
// Optional: define BUTTON_CONDITIONER_AUTO_REPEAT_EN for up/down auto-repeat.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int unsigned DEBOUNCE_TIME_IN_MS         = 10,
    parameter int unsigned REPEAT_DELAY_IN_MS          = 500,
    parameter int unsigned REPEAT_RATE_IN_HZ           = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_c,
    input  logic btn_u,
    input  logic btn_d,
    input  logic btn_l,
    input  logic btn_r,
    output logic set,
    output logic up,
    output logic down,
    output logic left,
    output logic right
);
    localparam int unsigned DEBOUNCE_CYCLES =
        cycles_from_ms(BOARD_CLOCK_FREQUENCY_IN_HZ, DEBOUNCE_TIME_IN_MS);

    logic [4:0] raw;
    logic [4:0] level;
    logic [4:0] press;
    logic [3:0] dir_level;
    logic [3:0] dir_press;
    logic [3:0] lvl_q;
    logic [3:0] rel;
    logic [3:0] evt;
    logic [1:0] pulse_ud;
    logic       conflict_ud;
    logic       conflict_lr;

    // Lane 0 is the centre button, lanes 1..4 are up, down, left, right
    assign raw = {btn_r, btn_l, btn_d, btn_u, btn_c};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .level(level[i]),
            .press(press[i])
        );
    end

    assign dir_level = level[4:1];
    assign dir_press = press[4:1];

    // Registered debounced releases, aligned with the press pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= '0;
            rel   <= '0;
        end else begin
            lvl_q <= dir_level;
            rel   <= lvl_q & ~dir_level;
        end
    end

    assign conflict_ud = dir_level[DIR_U] & dir_level[DIR_D];
    assign conflict_lr = dir_level[DIR_L] & dir_level[DIR_R];

    // A button fires on its own press, or when its opposite lets go while it is held
    assign evt[DIR_U] = (dir_press[DIR_U] | (rel[DIR_D] & dir_level[DIR_U])) & ~conflict_ud;
    assign evt[DIR_D] = (dir_press[DIR_D] | (rel[DIR_U] & dir_level[DIR_D])) & ~conflict_ud;
    assign evt[DIR_L] = (dir_press[DIR_L] | (rel[DIR_R] & dir_level[DIR_L])) & ~conflict_lr;
    assign evt[DIR_R] = (dir_press[DIR_R] | (rel[DIR_L] & dir_level[DIR_R])) & ~conflict_lr;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int unsigned REPEAT_DELAY_CYCLES =
        cycles_from_ms(BOARD_CLOCK_FREQUENCY_IN_HZ, REPEAT_DELAY_IN_MS);
    localparam int unsigned REPEAT_PERIOD_CYCLES =
        period_from_rate(BOARD_CLOCK_FREQUENCY_IN_HZ, REPEAT_RATE_IN_HZ);
    localparam int unsigned RCW = cnt_width(
        (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD_CYCLES - 1);

    for (genvar a = 0; a < 2; a++) begin : g_rpt
        rpt_state_t     state;
        rpt_state_t     state_next;
        logic [RCW-1:0] cnt;
        logic           held;
        logic           pulse;

        // Held means still pressed and not cancelled by the opposite button
        assign held = dir_level[a] & ~conflict_ud;

        // State register
        always_ff @(posedge clk) begin
            if (rst)
                state <= IDLE;
            else
                state <= state_next;
        end

        // Next-state logic
        always_comb begin
            state_next = state;
            case (state)
                IDLE:    if (evt[a]) state_next = DELAY;
                DELAY:   if (!held) state_next = IDLE;
                         else if (cnt == DELAY_LAST) state_next = REPEAT;
                REPEAT:  if (!held) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        // Pulse output: initial press, end of the delay, then once per period
        always_comb begin
            pulse = 1'b0;
            case (state)
                IDLE:    pulse = evt[a];
                DELAY:   pulse = held && (cnt == DELAY_LAST);
                REPEAT:  pulse = held && (cnt == PERIOD_LAST);
                default: pulse = 1'b0;
            endcase
        end

        // Interval counter: restarts on every state change and each repeat
        always_ff @(posedge clk) begin
            if (rst)
                cnt <= '0;
            else if (state != state_next)
                cnt <= '0;
            else if (state == REPEAT && cnt == PERIOD_LAST)
                cnt <= '0;
            else if (state != IDLE)
                cnt <= cnt + 1'b1;
        end

        assign pulse_ud[a] = pulse;
    end
`else
    assign pulse_ud = evt[DIR_D:DIR_U];
`endif

    // Registered outputs; set toggles on each centre press
    always_ff @(posedge clk) begin
        if (rst) begin
            set   <= 1'b0;
            up    <= 1'b0;
            down  <= 1'b0;
            left  <= 1'b0;
            right <= 1'b0;
        end else begin
            set   <= set ^ press[0];
            up    <= pulse_ud[DIR_U];
            down  <= pulse_ud[DIR_D];
            left  <= evt[DIR_L];
            right <= evt[DIR_R];
        end
    end

endmodule
